// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
//   N read ports, M write ports with per-byte enables. When several ports hit
//   the same register, bytes merge and the highest-numbered port wins each byte.
//   Optional write-to-read bypass, optional registered read data, and a clear
//   sweep that zeroes one register per cycle.
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_writeEn        per-write-port enable
//   i_writeAddr      packed write addresses, port p at [p*IndexWidth +: IndexWidth]
//   i_writeData      packed write data, port p at [p*DataWidth +: DataWidth]
//   i_writeByteEn    packed byte enables, port p at [p*(DataWidth/8) +: DataWidth/8]
//   i_readAddr       packed read addresses
//   o_readData       packed read data
//   i_clearReq       starts a clear sweep (pulse; ignored while sweeping)
//   o_clearBusy      sweep in progress, writes ignored
//   o_writeConflict  pulse: two or more enabled ports hit the same valid address last cycle
//   o_debugRegs      flattened register contents
//
// Sweep FSM states:
//   state    | meaning
//   ST_IDLE  | normal operation, waiting for i_clearReq
//   ST_SWEEP | zeroing register r_cnt each cycle, writes ignored
module regfile_mp #(
    parameter int DataWidth      = 32,
    parameter int NumRegs        = 32,
    parameter int IndexWidth     = $clog2(NumRegs),
    parameter int NumReadPorts   = 2,
    parameter int NumWritePorts  = 2,
    parameter bit ZeroReg        = 1'b1,
    parameter bit Bypass         = 1'b1,
    parameter bit RegisteredRead = 1'b0
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic [NumWritePorts-1:0]                i_writeEn,
    input  logic [NumWritePorts*IndexWidth-1:0]     i_writeAddr,
    input  logic [NumWritePorts*DataWidth-1:0]      i_writeData,
    input  logic [NumWritePorts*(DataWidth/8)-1:0]  i_writeByteEn,
    input  logic [NumReadPorts*IndexWidth-1:0]      i_readAddr,
    output logic [NumReadPorts*DataWidth-1:0]       o_readData,
    input  logic                                    i_clearReq,
    output logic                                    o_clearBusy,
    output logic                                    o_writeConflict,
    output logic [NumRegs*DataWidth-1:0]            o_debugRegs
);
    localparam int NumBytes = DataWidth / 8;
    localparam logic [IndexWidth:0]   LP_NUM_REGS = (IndexWidth+1)'(NumRegs);
    localparam logic [IndexWidth-1:0] LP_LAST     = IndexWidth'(NumRegs - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

    state_t                 r_state;
    logic [IndexWidth-1:0]  r_cnt;
    logic                   r_clearBusy;
    logic                   r_writeConflict;
    logic [DataWidth-1:0]   r_regs [NumRegs];

    logic [NumWritePorts-1:0] w_wvalid;
    logic [DataWidth-1:0]     w_next [NumRegs];
    logic [DataWidth-1:0]     w_rd   [NumReadPorts];
    logic                     w_conflict;

    // Address beyond the array, or register 0 when it is hardwired, is not writable.
    function automatic logic addr_valid(input logic [IndexWidth-1:0] a);
        return ({1'b0, a} < LP_NUM_REGS) && !(ZeroReg && (a == '0));
    endfunction

    always_comb begin
        for (int p = 0; p < NumWritePorts; p++) begin
            w_wvalid[p] = i_writeEn[p] && addr_valid(i_writeAddr[p*IndexWidth +: IndexWidth]);
        end
    end

    // Post-write value of every register. Ports are applied in ascending order
    // so the highest-numbered port ends up owning each byte it enables.
    always_comb begin
        for (int r = 0; r < NumRegs; r++) begin
            w_next[r] = r_regs[r];
            for (int p = 0; p < NumWritePorts; p++) begin
                if (w_wvalid[p] && !r_clearBusy &&
                    (i_writeAddr[p*IndexWidth +: IndexWidth] == IndexWidth'(r))) begin
                    for (int b = 0; b < NumBytes; b++) begin
                        if (i_writeByteEn[p*NumBytes + b]) begin
                            w_next[r][b*8 +: 8] = i_writeData[p*DataWidth + b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Conflict looks only at enables and addresses, so it still flags while sweeping.
    always_comb begin
        w_conflict = 1'b0;
        for (int p = 0; p < NumWritePorts; p++) begin
            for (int q = p + 1; q < NumWritePorts; q++) begin
                if (w_wvalid[p] && w_wvalid[q] &&
                    (i_writeAddr[p*IndexWidth +: IndexWidth] == i_writeAddr[q*IndexWidth +: IndexWidth])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // Addresses that match no register read as zero. w_next equals r_regs while
    // sweeping, so bypass is naturally inert then; the explicit gate documents it.
    always_comb begin
        for (int i = 0; i < NumReadPorts; i++) begin
            w_rd[i] = '0;
            for (int r = 0; r < NumRegs; r++) begin
                if (i_readAddr[i*IndexWidth +: IndexWidth] == IndexWidth'(r)) begin
                    w_rd[i] = (Bypass && !r_clearBusy) ? w_next[r] : r_regs[r];
                end
            end
        end
    end

    generate
        if (RegisteredRead) begin : g_reg_read
            logic [NumReadPorts*DataWidth-1:0] r_readData;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_readData <= '0;
                end else begin
                    for (int i = 0; i < NumReadPorts; i++) begin
                        r_readData[i*DataWidth +: DataWidth] <= w_rd[i];
                    end
                end
            end
            assign o_readData = r_readData;
        end else begin : g_comb_read
            always_comb begin
                for (int i = 0; i < NumReadPorts; i++) begin
                    o_readData[i*DataWidth +: DataWidth] = w_rd[i];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_clearBusy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clearReq) begin
                        r_state     <= ST_SWEEP;
                        r_cnt       <= '0;
                        r_clearBusy <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (r_cnt == LP_LAST) begin
                        r_state     <= ST_IDLE;
                        r_clearBusy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_clearBusy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_writeConflict <= 1'b0;
        end else begin
            r_writeConflict <= w_conflict;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int r = 0; r < NumRegs; r++) begin
            if (i_rst) begin
                r_regs[r] <= '0;
            end else if (r_clearBusy && (r_cnt == IndexWidth'(r))) begin
                r_regs[r] <= '0;
            end else begin
                r_regs[r] <= w_next[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NumRegs; r++) begin
            o_debugRegs[r*DataWidth +: DataWidth] = r_regs[r];
        end
    end

    assign o_clearBusy     = r_clearBusy;
    assign o_writeConflict = r_writeConflict;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three instances share one stimulus stream
// (bypass/combinational, no-bypass/combinational, bypass/registered) and are
// compared against a register-array model kept here.
module tb_regfile_mp;
    localparam int DW  = 32;
    localparam int NR  = 20;
    localparam int IW  = 5;
    localparam int NRP = 2;
    localparam int NWP = 2;
    localparam int NB  = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NWP-1:0]    wen;
    logic [NWP*IW-1:0] waddr;
    logic [NWP*DW-1:0] wdata;
    logic [NWP*NB-1:0] wbe;
    logic [NRP*IW-1:0] raddr;
    logic              clr;

    logic [NRP*DW-1:0] rd_a, rd_b, rd_c;
    logic              busy_a, busy_b, busy_c;
    logic              cf_a, cf_b, cf_c;
    logic [NR*DW-1:0]  dbg_a, dbg_b, dbg_c;

    always #5 clk = ~clk;

    regfile_mp #(.DataWidth(DW), .NumRegs(NR), .NumReadPorts(NRP), .NumWritePorts(NWP),
                 .ZeroReg(1'b1), .Bypass(1'b1), .RegisteredRead(1'b0)) u_byp (
        .i_clk(clk), .i_rst(rst), .i_writeEn(wen), .i_writeAddr(waddr), .i_writeData(wdata),
        .i_writeByteEn(wbe), .i_readAddr(raddr), .o_readData(rd_a), .i_clearReq(clr),
        .o_clearBusy(busy_a), .o_writeConflict(cf_a), .o_debugRegs(dbg_a));

    regfile_mp #(.DataWidth(DW), .NumRegs(NR), .NumReadPorts(NRP), .NumWritePorts(NWP),
                 .ZeroReg(1'b1), .Bypass(1'b0), .RegisteredRead(1'b0)) u_nobyp (
        .i_clk(clk), .i_rst(rst), .i_writeEn(wen), .i_writeAddr(waddr), .i_writeData(wdata),
        .i_writeByteEn(wbe), .i_readAddr(raddr), .o_readData(rd_b), .i_clearReq(clr),
        .o_clearBusy(busy_b), .o_writeConflict(cf_b), .o_debugRegs(dbg_b));

    regfile_mp #(.DataWidth(DW), .NumRegs(NR), .NumReadPorts(NRP), .NumWritePorts(NWP),
                 .ZeroReg(1'b1), .Bypass(1'b1), .RegisteredRead(1'b1)) u_regrd (
        .i_clk(clk), .i_rst(rst), .i_writeEn(wen), .i_writeAddr(waddr), .i_writeData(wdata),
        .i_writeByteEn(wbe), .i_readAddr(raddr), .o_readData(rd_c), .i_clearReq(clr),
        .o_clearBusy(busy_c), .o_writeConflict(cf_c), .o_debugRegs(dbg_c));

    // Reference model
    logic [DW-1:0] m [NR];
    logic [DW-1:0] m_rc [NRP];
    bit            m_busy  = 1'b0;
    int            m_pos   = 0;
    bit            m_conf  = 1'b0;
    bit            m_known = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int waddr_of(input int p);
        return int'(waddr[p*IW +: IW]);
    endfunction

    function automatic bit wvalid(input int p);
        int a;
        a = waddr_of(p);
        return wen[p] && (a < NR) && (a != 0);
    endfunction

    // Apply the enabled writes to a copy of register r, lower ports first.
    function automatic logic [DW-1:0] merged(input int r);
        logic [DW-1:0] v;
        v = m[r];
        if (!m_busy) begin
            for (int p = 0; p < NWP; p++) begin
                if (wvalid(p) && waddr_of(p) == r) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wbe[p*NB + b]) v[b*8 +: 8] = wdata[p*DW + b*8 +: 8];
                    end
                end
            end
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] rd_exp(input int a, input bit byp);
        if (a >= NR) return '0;
        return byp ? merged(a) : m[a];
    endfunction

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0; wbe = '0; clr = 1'b0; rst = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        wen[p] = 1'b1;
        waddr[p*IW +: IW] = IW'(a);
        wdata[p*DW +: DW] = d;
        wbe[p*NB +: NB]   = be;
    endtask

    task automatic set_raddr(input int a0, input int a1);
        raddr[0 +: IW]  = IW'(a0);
        raddr[IW +: IW] = IW'(a1);
    endtask

    // One clock cycle: inputs are set at the falling edge before calling.
    task automatic step();
        logic [DW-1:0] exp_a [NRP];
        logic [DW-1:0] exp_b [NRP];
        logic [DW-1:0] nxt   [NR];
        bit conf;
        #1;
        for (int i = 0; i < NRP; i++) begin
            exp_a[i] = rd_exp(int'(raddr[i*IW +: IW]), 1'b1);
            exp_b[i] = rd_exp(int'(raddr[i*IW +: IW]), 1'b0);
            if (m_known) begin
                check("rd_bypass", rd_a[i*DW +: DW], exp_a[i]);
                check("rd_nobypass", rd_b[i*DW +: DW], exp_b[i]);
            end
        end
        conf = 1'b0;
        for (int p = 0; p < NWP; p++)
            for (int q = p + 1; q < NWP; q++)
                if (wvalid(p) && wvalid(q) && waddr_of(p) == waddr_of(q)) conf = 1'b1;
        for (int r = 0; r < NR; r++) nxt[r] = merged(r);
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NR; r++) m[r] = '0;
            for (int i = 0; i < NRP; i++) m_rc[i] = '0;
            m_busy = 1'b0; m_pos = 0; m_conf = 1'b0; m_known = 1'b1;
        end else begin
            for (int r = 0; r < NR; r++) m[r] = nxt[r];
            if (m_busy) begin
                m[m_pos] = '0;
                m_pos++;
                if (m_pos == NR) m_busy = 1'b0;
            end else if (clr) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end
            m_conf = conf;
            m_rc   = exp_a;
        end
        #1;
        check("clearBusy", {31'd0, busy_a}, {31'd0, m_busy});
        check("writeConflict", {31'd0, cf_a}, {31'd0, m_conf});
        for (int i = 0; i < NRP; i++) check("rd_registered", rd_c[i*DW +: DW], m_rc[i]);
        for (int r = 0; r < NR; r++) check("debugRegs", dbg_a[r*DW +: DW], m[r]);
        @(negedge clk);
    endtask

    initial begin
        int n;
        idle();
        set_raddr(0, 0);
        rst = 1'b1;
        @(negedge clk);
        step();
        step();

        // Reset state, then a single full write to address 5
        idle();
        #1;
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_conflict", {31'd0, cf_a}, 32'd0);
        check("reset_regs_nonzero", {31'd0, |dbg_a}, 32'd0);
        wr(0, 5, 32'hDEADBEEF, 4'hF);
        set_raddr(5, 1);
        step();
        idle();
        #1;
        check("t1_read_addr5", rd_a[0 +: DW], 32'hDEADBEEF);
        check("t1_read_reg1", rd_a[DW +: DW], 32'h0);
        step();

        // Byte merge with conflict on register 7
        wr(0, 7, 32'h11223344, 4'hF);
        step();
        idle();
        wr(0, 7, 32'hAAAAAAAA, 4'h3);
        wr(1, 7, 32'hBBBBBBBB, 4'h6);
        step();
        idle();
        #1;
        check("t2_merge_reg7", dbg_a[7*DW +: DW], 32'h11BBBBAA);
        check("t2_conflict_high", {31'd0, cf_a}, 32'd1);
        step();
        check("t2_conflict_low", {31'd0, cf_a}, 32'd0);

        // Bypass versus pre-write value
        wr(0, 3, 32'h12345678, 4'hF);
        step();
        idle();
        wr(0, 3, 32'h000000FF, 4'hF);
        set_raddr(3, 7);
        #1;
        check("t3_bypass", rd_a[0 +: DW], 32'h000000FF);
        check("t3_nobypass", rd_b[0 +: DW], 32'h12345678);
        step();
        idle();

        // Register 0 and out-of-range address
        wr(0, 0, 32'h00000055, 4'hF);
        wr(1, 25, 32'h00000055, 4'hF);
        set_raddr(0, 25);
        #1;
        check("t4_read_zero", rd_a[0 +: DW], 32'h0);
        check("t4_read_invalid", rd_a[DW +: DW], 32'h0);
        step();
        idle();
        check("t4_no_conflict", {31'd0, cf_a}, 32'd0);

        // Fill, then sweep with a dropped mid-sweep write
        for (int r = 1; r < NR; r++) begin
            idle();
            wr(0, r, DW'(r + 1), 4'hF);
            step();
        end
        idle();
        set_raddr(19, 9);
        clr = 1'b1;
        step();
        idle();
        n = 0;
        for (int k = 0; k < 2 * NR && busy_a; k++) begin
            if (k == 5) wr(0, 9, 32'h0000CAFE, 4'hF);
            if (k == 8) clr = 1'b1;
            step();
            idle();
            n++;
        end
        check("t5_sweep_cycles", DW'(n), DW'(NR));
        check("t5_regs_cleared", {31'd0, |dbg_a}, 32'd0);

        // Reset in the middle of a sweep
        wr(0, 11, 32'h0BADF00D, 4'hF);
        step();
        idle();
        clr = 1'b1;
        step();
        idle();
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        idle();
        #1;
        check("t6_busy_after_rst", {31'd0, busy_a}, 32'd0);
        check("t6_regs_after_rst", {31'd0, |dbg_a}, 32'd0);
        wr(0, 2, 32'h00000012, 4'hF);
        step();
        idle();
        set_raddr(2, 11);
        #1;
        check("t6_readback", rd_a[0 +: DW], 32'h00000012);
        step();

        // Random traffic, addresses biased toward collisions
        for (int it = 0; it < 400; it++) begin
            idle();
            wen = NWP'($urandom);
            for (int p = 0; p < NWP; p++) begin
                if ($urandom_range(0, 2) == 0) waddr[p*IW +: IW] = IW'($urandom_range(0, 31));
                else waddr[p*IW +: IW] = IW'($urandom_range(0, 4));
            end
            wdata = {$urandom, $urandom};
            wbe   = (NWP*NB)'($urandom);
            for (int i = 0; i < NRP; i++) begin
                if ($urandom_range(0, 1) == 0) raddr[i*IW +: IW] = waddr[($urandom_range(0, NWP-1))*IW +: IW];
                else raddr[i*IW +: IW] = IW'($urandom_range(0, 31));
            end
            clr = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
